axis_tbcall_mc: RTL and testbench

Multi-channel successor to the single-channel testbench-call trigger. It watches N emulator-side trigger inputs and latches each trigger as a pending call. A round-robin arbiter serialises the pending calls to the host-side task-call interface one at a time. While a call is outstanding the block holds a stop request to freeze emulation, and it reports per-channel completion and overflow.

---
 rtl/axis_tbcall_pkg.sv | 8 +
 rtl/axis_tbcall_rr_arb.sv | 25 ++
 rtl/axis_tbcall_mc.sv | 65 ++++++
 tb/tb_axis_tbcall_mc.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_tbcall_pkg.sv
// axis_tbcall_pkg: shared FSM type, channel limit and call_id sizing for the multi-channel tbcall trigger.
package axis_tbcall_pkg;
    localparam int MAX_NCH = 32;
    typedef enum logic [1:0] {IDLE, CALL, GAP} state_t;
    function automatic int idw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/axis_tbcall_rr_arb.sv
// axis_tbcall_rr_arb: picks the first requester strictly after ptr, wrapping NCH-1 -> 0.
module axis_tbcall_rr_arb import axis_tbcall_pkg::*; #(
    parameter int NCH = 4,
    parameter int IDW = idw_f(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_any
);
    logic [IDW-1:0] idx;
    always_comb begin
        gnt_id = '0;
        gnt_any = 1'b0;
        idx = '0;
        // scanning from the farthest candidate back lets the nearest one win
        for (int k = NCH; k >= 1; k--) begin
            idx = IDW'((int'(ptr) + k) % NCH);
            if (req[idx]) begin
                gnt_id = idx;
                gnt_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/axis_tbcall_mc.sv
// axis_tbcall_mc: latches per-channel triggers as pending calls and serialises them to the host.
module axis_tbcall_mc import axis_tbcall_pkg::*; #(
    parameter int   NCH = 4,
    parameter logic EDGE_MODE = 1'b1,
    parameter int   IDW = idw_f(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] s,
    input  logic [NCH-1:0] ch_en,
    input  logic           pui,
    output logic           call_valid,
    output logic [IDW-1:0] call_id,
    input  logic           call_ack,
    output logic           stop_req,
    output logic [NCH-1:0] so,
    output logic [NCH-1:0] pend,
    output logic [NCH-1:0] ovf,
    input  logic           ovf_clr
);
    state_t state, state_d;
    logic [NCH-1:0] s_q, trig, clr, req;
    logic [IDW-1:0] ptr, ptr_d, id_d, gnt_id;
    logic gnt_any, ack_fire;

    assign req = pend & ch_en;
    assign call_valid = (state == CALL);
    assign stop_req = call_valid;

    axis_tbcall_rr_arb #(.NCH(NCH), .IDW(IDW)) u_arb (
        .req(req),
        .ptr(ptr),
        .gnt_id(gnt_id),
        .gnt_any(gnt_any)
    );

    always_comb begin
        trig = EDGE_MODE ? (s & ~s_q & ch_en) : (s & ch_en);
        ack_fire = (state == CALL) && call_ack;
        clr = ack_fire ? (NCH'(1) << call_id) : '0;
        state_d = (state == IDLE && gnt_any) ? CALL : ack_fire ? GAP : (state == GAP) ? IDLE : state;
        id_d = (state == IDLE && gnt_any) ? gnt_id : call_id;
        ptr_d = ack_fire ? call_id : ptr;
    end

    // a new trigger coinciding with its own ack re-arms pend without counting as overflow
    always_ff @(posedge clk) begin
        s_q <= s;
        if (rst) begin
            state <= IDLE;
            ptr <= IDW'(NCH - 1);
            call_id <= '0;
            so <= '0;
            pend <= '0;
            ovf <= '0;
        end else begin
            state <= state_d;
            ptr <= ptr_d;
            call_id <= id_d;
            so <= clr;
            pend <= pui ? '0 : ((pend & ~clr) | trig);
            ovf <= pui ? '0 : ((ovf & ~{NCH{ovf_clr}}) | (EDGE_MODE ? (trig & pend & ~clr) : '0));
        end
    end
endmodule

// File: tb/tb_axis_tbcall_mc.sv
// tb_axis_tbcall_mc: directed stimulus against a behavioural call model, plus a level-mode instance.
module tb_axis_tbcall_mc;
    localparam int N = 4;
    logic clk = 1'b0, rst = 1'b1, pui = 1'b0, call_ack = 1'b0, ovf_clr = 1'b0, ack2 = 1'b0;
    logic [N-1:0] s = '0, ch_en = '1, s2 = '0;
    logic call_valid, stop_req, cv2, stop2;
    logic [1:0] call_id, id2;
    logic [N-1:0] so, pend, ovf, so2, pend2, ovf2;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    axis_tbcall_mc #(.NCH(N), .EDGE_MODE(1'b1)) dut (
        .clk(clk), .rst(rst), .s(s), .ch_en(ch_en), .pui(pui),
        .call_valid(call_valid), .call_id(call_id), .call_ack(call_ack), .stop_req(stop_req),
        .so(so), .pend(pend), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    axis_tbcall_mc #(.NCH(N), .EDGE_MODE(1'b0)) dut_lvl (
        .clk(clk), .rst(rst), .s(s2), .ch_en(4'hF), .pui(1'b0),
        .call_valid(cv2), .call_id(id2), .call_ack(ack2), .stop_req(stop2),
        .so(so2), .pend(pend2), .ovf(ovf2), .ovf_clr(1'b0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a call is either outstanding on m_cur or not; after release one decision slot is skipped.
    logic [N-1:0] m_pend = '0, m_ovf = '0, m_so = '0, m_sq = '0;
    logic m_valid = 1'b0, started = 1'b0;
    int m_cur = 0, m_last = N - 1, m_quiet = 0;

    always @(posedge clk) begin
        logic [N-1:0] np, no, sv;
        logic t, c, acked;
        int g;
        np = '0;
        no = '0;
        sv = '0;
        g = -1;
        acked = m_valid && call_ack;
        if (rst) begin
            m_pend <= '0;
            m_ovf <= '0;
            m_so <= '0;
            m_valid <= 1'b0;
            m_cur <= 0;
            m_last <= N - 1;
            m_quiet <= 0;
        end else begin
            if (!m_valid && m_quiet == 0)
                for (int k = N; k >= 1; k--)
                    if (m_pend[(m_last + k) % N] && ch_en[(m_last + k) % N]) g = (m_last + k) % N;
            for (int i = 0; i < N; i++) begin
                t = s[i] && !m_sq[i] && ch_en[i];
                c = acked && (i == m_cur);
                sv[i] = c;
                np[i] = !pui && (t || (m_pend[i] && !c));
                no[i] = !pui && ((t && m_pend[i] && !c) || (m_ovf[i] && !ovf_clr));
            end
            m_pend <= np;
            m_ovf <= no;
            m_so <= sv;
            if (acked) begin
                m_valid <= 1'b0;
                m_last <= m_cur;
                m_quiet <= 1;
            end else if (g >= 0) begin
                m_valid <= 1'b1;
                m_cur <= g;
            end else if (!m_valid && m_quiet > 0) begin
                m_quiet <= m_quiet - 1;
            end
        end
        m_sq <= s;
        started <= 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("call_valid", call_valid, m_valid);
            chk("stop_req", stop_req, m_valid);
            chk("pend", pend, m_pend);
            chk("ovf", ovf, m_ovf);
            chk("so", so, m_so);
            if (m_valid) chk("call_id", call_id, m_cur);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!call_valid && n < 20) begin
            tick();
            n++;
        end
        chk("wait_valid", call_valid, 1);
    endtask

    task automatic serve(input int id);
        wait_valid();
        chk("serve_id", call_id, id);
        call_ack = 1'b1;
        tick();
        call_ack = 1'b0;
        chk("serve_so", so, 1 << id);
        chk("serve_drop", call_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        int n, gap;
        s = 4'b0001;
        tick();
        tick();
        chk("rst_valid", call_valid, 0);
        chk("rst_stop", stop_req, 0);
        chk("rst_id", call_id, 0);
        chk("rst_pend", pend, 0);
        chk("rst_so", so, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("held_pend", pend, 0);
        chk("held_valid", call_valid, 0);
        s = 4'b0000;
        tick();
        s = 4'b0001;
        tick();
        chk("lat_pend", pend, 4'b0001);
        chk("lat_valid_t1", call_valid, 0);
        tick();
        chk("lat_valid", call_valid, 1);
        chk("lat_id", call_id, 0);
        chk("lat_stop", stop_req, 1);
        call_ack = 1'b1;
        tick();
        call_ack = 1'b0;
        chk("ack0_so", so, 4'b0001);
        chk("ack0_pend", pend, 0);
        tick();
        s = 4'b0101;
        tick();
        chk("p2_pend", pend, 4'b0100);
        tick();
        chk("p2_valid", call_valid, 1);
        chk("p2_id", call_id, 2);
        call_ack = 1'b1;
        tick();
        call_ack = 1'b0;
        chk("p2_so", so, 4'b0100);
        chk("p2_pend0", pend, 0);
        chk("p2_gap1", call_valid, 0);
        tick();
        chk("p2_so_once", so, 0);
        chk("p2_gap2", call_valid, 0);

        s = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s = 4'b1011;
        tick();
        chk("rr_pend", pend, 4'b1011);
        serve(0);
        serve(1);
        serve(3);
        s = 4'b0000;
        tick();
        s = 4'b0011;
        tick();
        serve(0);
        serve(1);

        s = 4'b0000;
        tick();
        s = 4'b0010;
        tick();
        s = 4'b0000;
        tick();
        s = 4'b0010;
        tick();
        chk("ovf_set", ovf, 4'b0010);
        chk("ovf_pend", pend, 4'b0010);
        tick();
        tick();
        chk("ovf_sticky", ovf, 4'b0010);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", ovf, 0);
        s = 4'b0000;
        tick();
        s = 4'b0010;
        call_ack = 1'b1;
        tick();
        call_ack = 1'b0;
        chk("coin_pend", pend, 4'b0010);
        chk("coin_ovf", ovf, 0);
        chk("coin_so", so, 4'b0010);
        s = 4'b0000;
        tick();
        s = 4'b0010;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_set_wins", ovf, 4'b0010);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr2", ovf, 0);
        serve(1);

        s = 4'b0000;
        tick();
        ch_en = 4'b1011;
        s = 4'b0100;
        tick();
        tick();
        chk("mask_pend", pend, 0);
        chk("mask_valid", call_valid, 0);
        ch_en = 4'b1111;
        tick();
        chk("unmask_pend", pend, 0);
        call_ack = 1'b1;
        tick();
        call_ack = 1'b0;
        chk("idle_ack_so", so, 0);

        s = 4'b0000;
        tick();
        s = 4'b0001;
        tick();
        wait_valid();
        s = 4'b0101;
        tick();
        chk("abort_pend_pre", pend, 4'b0101);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", call_valid, 0);
        chk("abort_stop", stop_req, 0);
        chk("abort_pend", pend, 0);
        chk("abort_so", so, 0);
        tick();
        chk("abort_so2", so, 0);
        chk("abort_valid2", call_valid, 0);

        s = 4'b0000;
        tick();
        s = 4'b0001;
        tick();
        wait_valid();
        pui = 1'b1;
        tick();
        pui = 1'b0;
        chk("pui_pend", pend, 0);
        chk("pui_valid", call_valid, 1);
        tick();
        call_ack = 1'b1;
        tick();
        call_ack = 1'b0;
        chk("pui_so", so, 4'b0001);
        chk("pui_drop", call_valid, 0);

        s2 = 4'b1000;
        for (int r = 0; r < 3; r++) begin
            n = 0;
            while (!cv2 && n < 20) begin
                tick();
                n++;
            end
            chk("lvl_valid", cv2, 1);
            chk("lvl_id", id2, 3);
            chk("lvl_stop", stop2, 1);
            ack2 = 1'b1;
            tick();
            ack2 = 1'b0;
            chk("lvl_so", so2, 4'b1000);
            chk("lvl_pend", pend2, 4'b1000);
            chk("lvl_ovf", ovf2, 0);
            gap = 0;
            while (!cv2 && gap < 20) begin
                gap++;
                tick();
            end
            chk("lvl_gap", gap, 2);
        end
        s2 = 4'b0000;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
